// File: rtl/rfg_axis_pkg.sv
// Shared types for the register-protocol byte stream: header layout and
// the frame-parser state encoding used by the arbiter.
package rfg_axis_pkg;

  localparam int HDR_WRITE_BIT = 0;
  localparam int HDR_READ_BIT  = 1;
  localparam int HDR_AINC_BIT  = 2;
  localparam int HDR_EXT_BIT   = 3;
  localparam int HDR_VCH_LSB   = 4;

  typedef struct packed {
    logic [3:0] vchannel;
    logic       extended_address;
    logic       address_increment;
    logic       read;
    logic       write;
  } header_t;

  typedef enum logic [2:0] {
    ST_ARB,
    ST_HEADER,
    ST_ADDR,
    ST_ADDRB,
    ST_LENA,
    ST_LENB,
    ST_PAYLOAD
  } state_t;

endpackage

// File: rtl/rfg_rr_arbiter.sv
// Combinational round-robin pick: first requester searching upward from
// i_last+1 with wrap. o_found is low when nobody requests.
module rfg_rr_arbiter #(
  parameter int NUM_PORTS = 4
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [3:0]           i_last,
  output logic [3:0]           o_idx,
  output logic                 o_found
);

  always_comb begin
    int w_p;
    o_idx   = '0;
    o_found = 1'b0;
    w_p     = 0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      w_p = (int'(i_last) + k) % NUM_PORTS;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (!o_found && (w_p == i) && i_req[i]) begin
          o_idx   = 4'(i);
          o_found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rfg_axis_frame_arbiter.sv
// N:1 AXI-Stream arbiter that holds a grant for one whole register-protocol
// frame, releasing on the exact last byte so frames never interleave.
module rfg_axis_frame_arbiter
  import rfg_axis_pkg::*;
#(
  parameter int NUM_PORTS      = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int ID_DEST_WIDTH  = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
  output logic [NUM_PORTS-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic [ID_DEST_WIDTH-1:0]        m_axis_tid,
  output logic                            grant_valid,
  output logic [3:0]                      grant_index,
  output logic                            frame_abort
);

  localparam int             TW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t          r_state;
  logic            r_grant_valid;
  logic [3:0]      r_grant_index;
  logic [3:0]      r_last_grant;
  logic            r_wr;
  logic            r_rd;
  logic            r_ext;
  logic [7:0]      r_len_lo;
  logic [16:0]     r_cnt;
  logic [TW-1:0]   r_idle;
  logic            r_frame_abort;

  logic [DATA_WIDTH-1:0] w_byte;
  logic                  w_vld;
  logic                  w_active;
  logic                  w_hs;
  logic                  w_last;
  logic [3:0]            w_win;
  logic                  w_found;
  logic [15:0]           w_len;

  rfg_rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_rr (
    .i_req   (s_axis_tvalid),
    .i_last  (r_last_grant),
    .o_idx   (w_win),
    .o_found (w_found)
  );

  assign w_active = (r_state != ST_ARB);

  // Pure mux, no buffering: the granted port sees the sink's ready directly.
  always_comb begin
    w_byte        = '0;
    w_vld         = 1'b0;
    s_axis_tready = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (r_grant_index == 4'(i)) begin
        w_byte           = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        w_vld            = s_axis_tvalid[i];
        s_axis_tready[i] = w_active && m_axis_tready;
      end
    end
  end

  assign w_hs  = w_active && w_vld && m_axis_tready;
  assign w_len = {w_byte[7:0], r_len_lo};

  always_comb begin
    w_last = 1'b0;
    case (r_state)
      ST_HEADER:  w_last = !(w_byte[HDR_WRITE_BIT] || w_byte[HDR_READ_BIT]);
      ST_LENB:    w_last = r_rd && !r_wr;
      ST_PAYLOAD: w_last = (r_cnt == 17'd1);
      default:    w_last = 1'b0;
    endcase
  end

  assign m_axis_tdata  = w_byte;
  assign m_axis_tvalid = w_active && w_vld;
  assign m_axis_tlast  = w_last && m_axis_tvalid;
  assign m_axis_tid    = ID_DEST_WIDTH'(r_grant_index);
  assign grant_valid   = r_grant_valid;
  assign grant_index   = r_grant_index;
  assign frame_abort   = r_frame_abort;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state       <= ST_ARB;
      r_grant_valid <= 1'b0;
      r_grant_index <= '0;
      r_last_grant  <= 4'(NUM_PORTS - 1);
      r_wr          <= 1'b0;
      r_rd          <= 1'b0;
      r_ext         <= 1'b0;
      r_len_lo      <= '0;
      r_cnt         <= '0;
      r_idle        <= '0;
      r_frame_abort <= 1'b0;
    end else begin
      r_frame_abort <= 1'b0;
      case (r_state)
        ST_ARB: begin
          r_idle <= '0;
          if (w_found) begin
            r_grant_index <= w_win;
            r_last_grant  <= w_win;
            r_grant_valid <= 1'b1;
            r_state       <= ST_HEADER;
          end
        end
        ST_HEADER: if (w_hs) begin
          r_wr  <= w_byte[HDR_WRITE_BIT];
          r_rd  <= w_byte[HDR_READ_BIT];
          r_ext <= w_byte[HDR_EXT_BIT];
          if (w_last) begin
            r_state       <= ST_ARB;
            r_grant_valid <= 1'b0;
          end else begin
            r_state <= ST_ADDR;
          end
        end
        ST_ADDR:  if (w_hs) r_state <= r_ext ? ST_ADDRB : ST_LENA;
        ST_ADDRB: if (w_hs) r_state <= ST_LENA;
        ST_LENA: if (w_hs) begin
          r_len_lo <= w_byte[7:0];
          r_state  <= ST_LENB;
        end
        ST_LENB: if (w_hs) begin
          // Write wins over read; a zero length means a full 64 KiB payload.
          if (r_wr) begin
            r_cnt   <= (w_len == 16'd0) ? 17'h10000 : {1'b0, w_len};
            r_state <= ST_PAYLOAD;
          end else begin
            r_state       <= ST_ARB;
            r_grant_valid <= 1'b0;
          end
        end
        ST_PAYLOAD: if (w_hs) begin
          r_cnt <= r_cnt - 17'd1;
          if (r_cnt == 17'd1) begin
            r_state       <= ST_ARB;
            r_grant_valid <= 1'b0;
          end
        end
        default: begin
          r_state       <= ST_ARB;
          r_grant_valid <= 1'b0;
        end
      endcase

      // Stalled mid-frame: abandon the frame so one dead interface cannot
      // lock out the others; the processor is reset by frame_abort.
      if (TIMEOUT_CYCLES != 0 && r_state != ST_ARB && r_state != ST_HEADER) begin
        if (w_hs) begin
          r_idle <= '0;
        end else if (r_idle == TO_LAST) begin
          r_idle        <= '0;
          r_frame_abort <= 1'b1;
          r_state       <= ST_ARB;
          r_grant_valid <= 1'b0;
        end else begin
          r_idle <= r_idle + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rfg_axis_frame_arbiter.sv
// Directed bench for rfg_axis_frame_arbiter: per-port byte sources, a
// sink log, and per-scenario tasks with hand-computed expectations.
module tb_rfg_axis_frame_arbiter;
  import rfg_axis_pkg::*;

  localparam int NP   = 4;
  localparam int DW   = 8;
  localparam int IW   = 8;
  localparam int TO   = 16;
  localparam int MAXB = 65600;

  logic             aclk = 1'b0;
  logic             aresetn = 1'b0;
  logic [NP*DW-1:0] s_axis_tdata = '0;
  logic [NP-1:0]    s_axis_tvalid = '0;
  logic [NP-1:0]    s_axis_tready;
  logic [DW-1:0]    m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tready = 1'b1;
  logic             m_axis_tlast;
  logic [IW-1:0]    m_axis_tid;
  logic             grant_valid;
  logic [3:0]       grant_index;
  logic             frame_abort;

  rfg_axis_frame_arbiter #(
    .NUM_PORTS(NP), .DATA_WIDTH(DW), .ID_DEST_WIDTH(IW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid),
    .grant_valid(grant_valid), .grant_index(grant_index), .frame_abort(frame_abort)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;

  logic [7:0] src_mem [NP][MAXB];
  int         src_len [NP];
  int         src_pos [NP];
  int         rdy_mode;
  int         cyc;

  logic [7:0] o_data [MAXB];
  logic [7:0] o_tid  [MAXB];
  logic       o_last [MAXB];
  int         o_cyc  [MAXB];
  int         n_out;
  int         n_abort;
  int         abort_cyc;
  int         multi_rdy = 0;

  task automatic drive();
    for (int i = 0; i < NP; i++) begin
      s_axis_tvalid[i]       = (src_pos[i] < src_len[i]);
      s_axis_tdata[i*8 +: 8] = (src_pos[i] < src_len[i]) ? src_mem[i][src_pos[i]] : 8'h00;
    end
    if (rdy_mode == 0) m_axis_tready = 1'b1;
    else               m_axis_tready = (cyc % 4 == 3) || ($urandom_range(0, 1) == 1);
  endtask

  task automatic step();
    logic [NP-1:0] hs;
    @(negedge aclk);
    hs = s_axis_tvalid & s_axis_tready;
    if ($countones(s_axis_tready) > 1) multi_rdy++;
    if (m_axis_tvalid && m_axis_tready && n_out < MAXB) begin
      o_data[n_out] = m_axis_tdata;
      o_tid[n_out]  = m_axis_tid;
      o_last[n_out] = m_axis_tlast;
      o_cyc[n_out]  = cyc;
      n_out++;
    end
    if (frame_abort) begin
      n_abort++;
      abort_cyc = cyc;
    end
    @(posedge aclk);
    #1;
    for (int i = 0; i < NP; i++) if (hs[i]) src_pos[i]++;
    cyc++;
    drive();
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    for (int i = 0; i < NP; i++) begin
      src_len[i] = 0;
      src_pos[i] = 0;
    end
    rdy_mode = 0;
    cyc = 0;
    drive();
    repeat (2) @(posedge aclk);
    #1;
    aresetn   = 1'b1;
    cyc       = 0;
    n_out     = 0;
    n_abort   = 0;
    abort_cyc = -1;
  endtask

  task automatic run(input int target, input int budget, input string name);
    int k = 0;
    while (n_out < target && k < budget) begin
      step();
      k++;
    end
    checks++;
    if (n_out < target) begin
      failures++;
      $display("FAIL %s: bytes forwarded %0d, required %0d within %0d cycles", name, n_out, target, budget);
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    src_len[0] = 1; src_pos[0] = 0; src_mem[0][0] = 8'h05;
    drive();
    @(posedge aclk);
    #1;
    checks++; if (s_axis_tready !== 4'b0000) begin failures++; $display("FAIL rst_tready: got %b exp 0000", s_axis_tready); end
    checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL rst_tvalid: got %b exp 0", m_axis_tvalid); end
    checks++; if (m_axis_tlast !== 1'b0) begin failures++; $display("FAIL rst_tlast: got %b exp 0", m_axis_tlast); end
    checks++; if (m_axis_tid !== 8'h00) begin failures++; $display("FAIL rst_tid: got %0h exp 0", m_axis_tid); end
    checks++; if (grant_valid !== 1'b0) begin failures++; $display("FAIL rst_grant_valid: got %b exp 0", grant_valid); end
    checks++; if (grant_index !== 4'h0) begin failures++; $display("FAIL rst_grant_index: got %0h exp 0", grant_index); end
    checks++; if (frame_abort !== 1'b0) begin failures++; $display("FAIL rst_abort: got %b exp 0", frame_abort); end
  endtask

  task automatic test_single_write();
    logic [7:0] exp_d [6] = '{8'h05, 8'h10, 8'h02, 8'h00, 8'hAA, 8'hBB};
    do_reset();
    for (int i = 0; i < 6; i++) src_mem[0][i] = exp_d[i];
    src_len[0] = 6;
    drive();
    run(6, 40, "single_write");
    for (int i = 0; i < 6; i++) begin
      checks++; if (o_data[i] !== exp_d[i]) begin failures++; $display("FAIL sw_data[%0d]: got %0h exp %0h", i, o_data[i], exp_d[i]); end
      checks++; if (o_tid[i] !== 8'h00) begin failures++; $display("FAIL sw_tid[%0d]: got %0h exp 0", i, o_tid[i]); end
      checks++; if (o_last[i] !== (i == 5)) begin failures++; $display("FAIL sw_last[%0d]: got %b exp %b", i, o_last[i], (i == 5)); end
    end
    checks++; if (o_cyc[0] !== 1) begin failures++; $display("FAIL sw_latency: first byte at cycle %0d exp 1", o_cyc[0]); end
    step(); step();
    checks++; if (n_out !== 6) begin failures++; $display("FAIL sw_count: got %0d exp 6", n_out); end
    checks++; if (grant_valid !== 1'b0) begin failures++; $display("FAIL sw_release: grant_valid %b exp 0", grant_valid); end
    checks++; if (dut.r_state !== ST_ARB) begin failures++; $display("FAIL sw_state: got %0d exp ARB", dut.r_state); end
  endtask

  task automatic test_two_reads();
    logic [7:0] frm [4] = '{8'h02, 8'h20, 8'h01, 8'h00};
    logic [7:0] exp_tid [12] = '{1, 1, 1, 1, 2, 2, 2, 2, 1, 1, 1, 1};
    do_reset();
    for (int i = 0; i < 8; i++) src_mem[1][i] = frm[i % 4];
    for (int i = 0; i < 4; i++) src_mem[2][i] = frm[i];
    src_len[1] = 8;
    src_len[2] = 4;
    drive();
    run(12, 80, "two_reads");
    for (int i = 0; i < 12; i++) begin
      checks++; if (o_tid[i] !== exp_tid[i]) begin failures++; $display("FAIL rr_tid[%0d]: got %0h exp %0h", i, o_tid[i], exp_tid[i]); end
      checks++; if (o_data[i] !== frm[i % 4]) begin failures++; $display("FAIL rr_data[%0d]: got %0h exp %0h", i, o_data[i], frm[i % 4]); end
      checks++; if (o_last[i] !== (i % 4 == 3)) begin failures++; $display("FAIL rr_last[%0d]: got %b exp %b", i, o_last[i], (i % 4 == 3)); end
    end
    checks++; if (o_cyc[4] - o_cyc[3] !== 2) begin failures++; $display("FAIL rr_bubble: gap %0d exp 2", o_cyc[4] - o_cyc[3]); end
  endtask

  task automatic test_ext_random();
    logic [7:0] exp_d [6] = '{8'h09, 8'h34, 8'h12, 8'h01, 8'h00, 8'h55};
    do_reset();
    for (int i = 0; i < 6; i++) src_mem[0][i] = exp_d[i];
    src_len[0] = 6;
    rdy_mode = 1;
    drive();
    run(6, 200, "ext_random");
    for (int i = 0; i < 6; i++) begin
      checks++; if (o_data[i] !== exp_d[i]) begin failures++; $display("FAIL ext_data[%0d]: got %0h exp %0h", i, o_data[i], exp_d[i]); end
      checks++; if (o_last[i] !== (i == 5)) begin failures++; $display("FAIL ext_last[%0d]: got %b exp %b", i, o_last[i], (i == 5)); end
    end
    rdy_mode = 0;
  endtask

  task automatic test_len_zero();
    int bad_d = 0;
    int n_last = 0;
    do_reset();
    src_mem[0][0] = 8'h01; src_mem[0][1] = 8'h00; src_mem[0][2] = 8'h00; src_mem[0][3] = 8'h00;
    for (int i = 0; i < 65536; i++) src_mem[0][4 + i] = 8'(i * 7 + 3);
    src_len[0] = 65540;
    drive();
    run(65540, 66000, "len_zero");
    for (int i = 0; i < 65540; i++) begin
      if (o_data[i] !== src_mem[0][i] || o_tid[i] !== 8'h00) bad_d++;
      if (o_last[i] === 1'b1) n_last++;
    end
    checks++; if (bad_d !== 0) begin failures++; $display("FAIL lz_data: %0d bad bytes exp 0", bad_d); end
    checks++; if (n_last !== 1) begin failures++; $display("FAIL lz_last_count: got %0d exp 1", n_last); end
    checks++; if (o_last[65539] !== 1'b1) begin failures++; $display("FAIL lz_last_pos: got %b exp 1", o_last[65539]); end
    step();
    checks++; if (grant_valid !== 1'b0) begin failures++; $display("FAIL lz_release: grant_valid %b exp 0", grant_valid); end
  endtask

  task automatic test_timeout_abort();
    logic [7:0] p3 [4] = '{8'h01, 8'h00, 8'h04, 8'h00};
    do_reset();
    for (int i = 0; i < 4; i++) src_mem[3][i] = p3[i];
    src_len[3] = 4;
    drive();
    repeat (3) step();
    src_mem[0][0] = 8'h00;
    src_len[0] = 1;
    drive();
    run(5, 80, "timeout_abort");
    for (int i = 0; i < 4; i++) begin
      checks++; if (o_tid[i] !== 8'h03) begin failures++; $display("FAIL to_tid[%0d]: got %0h exp 3", i, o_tid[i]); end
    end
    checks++; if (n_abort !== 1) begin failures++; $display("FAIL to_abort_count: got %0d exp 1", n_abort); end
    checks++; if (abort_cyc - o_cyc[3] !== 17) begin failures++; $display("FAIL to_abort_time: got %0d exp 17", abort_cyc - o_cyc[3]); end
    checks++; if (o_cyc[4] - abort_cyc !== 1) begin failures++; $display("FAIL to_regrant: got %0d exp 1", o_cyc[4] - abort_cyc); end
    checks++; if (o_tid[4] !== 8'h00) begin failures++; $display("FAIL hdr0_tid: got %0h exp 0", o_tid[4]); end
    checks++; if (o_data[4] !== 8'h00) begin failures++; $display("FAIL hdr0_data: got %0h exp 0", o_data[4]); end
    checks++; if (o_last[4] !== 1'b1) begin failures++; $display("FAIL hdr0_last: got %b exp 1", o_last[4]); end
    checks++; if (o_last[3] !== 1'b0) begin failures++; $display("FAIL to_nolast: got %b exp 0", o_last[3]); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    src_mem[0][0] = 8'h01; src_mem[0][1] = 8'h00; src_mem[0][2] = 8'h08; src_mem[0][3] = 8'h00;
    for (int i = 0; i < 8; i++) src_mem[0][4 + i] = 8'(8'h10 + i);
    src_len[0] = 12;
    drive();
    run(7, 40, "reset_mid");
    checks++; if (s_axis_tready !== 4'b0001) begin failures++; $display("FAIL rm_pre_tready: got %b exp 0001", s_axis_tready); end
    #2;
    aresetn = 1'b0;
    #1;
    checks++; if (s_axis_tready !== 4'b0000) begin failures++; $display("FAIL rm_tready: got %b exp 0000", s_axis_tready); end
    checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL rm_tvalid: got %b exp 0", m_axis_tvalid); end
    checks++; if (grant_valid !== 1'b0) begin failures++; $display("FAIL rm_grant_valid: got %b exp 0", grant_valid); end
    checks++; if (dut.r_state !== ST_ARB) begin failures++; $display("FAIL rm_state: got %0d exp ARB", dut.r_state); end
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NP; i++) begin
      src_len[i] = 0;
      src_pos[i] = 0;
    end
    rdy_mode = 0;
    cyc = 0;
    n_out = 0;
    n_abort = 0;
    abort_cyc = -1;
    test_reset();
    test_single_write();
    test_two_reads();
    test_ext_random();
    test_len_zero();
    test_timeout_abort();
    test_reset_mid();
    checks++;
    if (multi_rdy !== 0) begin
      failures++;
      $display("FAIL onehot_ready: %0d cycles with several readies, exp 0", multi_rdy);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rfg_axis_frame_arbiter.md
# rfg_axis_frame_arbiter

Frame-aware N:1 AXI-Stream arbiter that lets several I/O interfaces (UART, SPI, USB bridges) share the single protocol-byte input of the register-file protocol processor. It grants one source at a time by round-robin and holds the grant until a complete register-protocol frame has passed. It then releases on the exact last byte, so frames from different interfaces never interleave. The granted port index goes out on `m_axis_tid`, so the protocol processor routes readback to the originating interface.

## Interface
- `NUM_PORTS`, 4: number of requesting slave ports (2..16).
- `DATA_WIDTH`, 8: byte lane width; fixed at 8 for the protocol.
- `ID_DEST_WIDTH`, 8: width of `m_axis_tid`.
- `TIMEOUT_CYCLES`, 65535: idle cycles tolerated mid-frame before abort; 0 disables.

- `aclk`  in  1  clock.
- `aresetn`  in  1  reset; asynchronous assert, active-low.
- `s_axis_tdata`  in  NUM_PORTS*DATA_WIDTH  per-port bytes; port i in slice [i*8+:8].
- `s_axis_tvalid`  in  NUM_PORTS  per-port valid.
- `s_axis_tready`  out  NUM_PORTS  per-port ready; only the granted bit may be 1.
- `m_axis_tdata`  out  DATA_WIDTH  granted port byte.
- `m_axis_tvalid`  out  1  granted port valid.
- `m_axis_tready`  in  1  protocol processor ready.
- `m_axis_tlast`  out  1  high on the final byte of a frame.
- `m_axis_tid`  out  ID_DEST_WIDTH  zero-extended granted port index.
- `grant_valid`  out  1  a port currently holds the grant.
- `grant_index`  out  4  current or last granted port.
- `frame_abort`  out  1  one-cycle pulse on timeout; system ORs it into the protocol processor reset.

## Operation
- States: ARB, HEADER, ADDR, ADDRB, LENA, LENB, PAYLOAD.
- **ARB:** if any `s_axis_tvalid`, register the round-robin winner: first valid port searching upward from `last_grant+1`, with wrap. Then go to HEADER.
- **HEADER:** on a handshake, capture the header byte. bit0=write, bit1=read, bit2=address_increment, bit3=extended_address, [7:4]=vchannel.
  - Neither read nor write set: single-byte frame, tlast=1, back to ARB. The processor discards it.
  - Otherwise go to ADDR.
- **ADDR:** on a handshake, go to ADDRB if extended, else LENA.
- **ADDRB:** on a handshake, go to LENA.
- **LENA:** capture length[7:0].
- **LENB:** capture length[15:8] and form the 16-bit length.
  - Write frame: load the 17-bit payload counter with length, where length 0 means 65536, matching processor wrap behaviour. Go to PAYLOAD.
  - Read frame (read=1, write=0): tlast=1 on this byte, back to ARB. A read frame has no payload.
  - write has priority when both bits are set.
- **PAYLOAD:** decrement the counter on each handshake. On the handshake with counter==1, assert tlast and go to ARB.
- **Datapath:** combinational mux of the granted port onto m_axis; `s_axis_tready[g] = m_axis_tready && state != ARB`. No buffering; tdata/tvalid ordering is preserved.
- **Timeout:** in any state except ARB and HEADER, count consecutive cycles with no handshake. Reaching TIMEOUT_CYCLES pulses `frame_abort`, drops the grant and returns to ARB. Partial bytes are not replayed.

## Timing
- Reset values: state=ARB, grant_valid=0, grant_index=0, last_grant=NUM_PORTS-1 (so port 0 wins first), all s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tid=0, frame_abort=0, counters 0.
- Grant latency: the first frame byte can transfer 1 cycle after a valid is first seen in ARB.
- Frame to next frame: 1 bubble cycle (the ARB cycle).
- Fairness:
  - A port that keeps requesting is not granted again until every other requester has had one frame.
  - A request from the grant holder during its frame's last byte is not honoured until the next ARB.
- Backpressure: `m_axis_tready`=0 stalls the granted port combinationally; counters advance only on handshakes.
- Reset mid-frame clears all state immediately (asynchronous). The protocol processor must be reset together with this block.

## Structure
- Shared package `rfg_axis_pkg`: `header_t` packed struct (vchannel, extended_address, address_increment, read, write), frame-parser state enum, and the header bit-position constants. The protocol processor also imports `header_t` from this package.
- One sub-module `rfg_rr_arbiter` (NUM_PORTS request vector, last-grant index in, winner index plus found flag out; purely combinational priority rotate). It is reusable elsewhere.
- The parser FSM, counters and mux stay in the top module.

## Test plan
- Single port 0 write frame 0x05, 0x10, 0x02, 0x00, 0xAA, 0xBB → 6 bytes forwarded, tid=0, tlast only on 0xBB, state back to ARB.
- Ports 1 and 2 both send read frames 0x02, 0x20, 0x01, 0x00 simultaneously after reset → port 1 frame complete first (tlast on byte 4), then port 2 with tid=2, no interleaving.
- Extended write 0x09, 0x34, 0x12, 0x01, 0x00, 0x55 with random m_axis_tready → 6 bytes, tlast on 0x55, every byte unchanged and in order.
- Write with length bytes 0x00, 0x00 → grant held for exactly 65536 payload bytes, tlast on the last one.
- Port 3 sends 0x01, 0x00, 0x04, 0x00 then stops, TIMEOUT_CYCLES=16 → frame_abort pulses 1 cycle after 16 idle cycles, pending port 0 granted next.
- Header byte 0x00 from port 0 → forwarded alone with tlast=1. Assert aresetn low mid-payload → all readies 0 and state ARB in the same cycle.
